// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    FREEZE = 2'b01,
    ERROR  = 2'b10
  } hz_state_t;

  localparam int DEFAULT_MAX_WAIT = 16;

  // A later stage can supply rs only if it really writes a non-x0 register.
  function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Execute-stage operand forwarding select; the memory stage wins over writeback.
import hazard_pkg::*;

module fwd_sel (
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output fwd_sel_t   sel
);

  always_comb begin
    sel = FWD_NONE;
    if (reg_hit(reg_write_m, rd_m, rs))
      sel = FWD_MEM;
    else if (reg_hit(reg_write_w, rd_w, rs))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stall/flush decode, memory-busy freeze with watchdog, forwarding.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
import hazard_pkg::*;

module hazard_unit #(
  parameter int MAX_WAIT  = DEFAULT_MAX_WAIT,
  parameter int CNT_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] destinationReg_e,
  input  logic       memRead_e,
  input  logic       pcSrc_e,
  input  logic [4:0] destinationReg_m,
  input  logic       regWrite_m,
  input  logic [4:0] destinationReg_w,
  input  logic       regWrite_w,
  input  logic       memBusy_m,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_w,
  output logic [1:0] forwardA_e,
  output logic [1:0] forwardB_e,
  output logic       hazard_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_stall_cnt,
  output logic [CNT_WIDTH-1:0] perf_flush_cnt,
  output logic [CNT_WIDTH-1:0] perf_freeze_cnt
`endif
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  hz_state_t         state, state_nxt;
  logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              load_use, freeze, redirect_do, stall_do;
  fwd_sel_t          fwd_a, fwd_b;

  fwd_sel u_fwd_a (
    .rs(rs1_e), .rd_m(destinationReg_m), .reg_write_m(regWrite_m),
    .rd_w(destinationReg_w), .reg_write_w(regWrite_w), .sel(fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs(rs2_e), .rd_m(destinationReg_m), .reg_write_m(regWrite_m),
    .rd_w(destinationReg_w), .reg_write_w(regWrite_w), .sel(fwd_b)
  );

  assign load_use = memRead_e && (destinationReg_e != 5'd0) &&
                    ((destinationReg_e == rs1_d) || (destinationReg_e == rs2_d));

  // Priority: freeze > redirect > load-use. A non-busy FREEZE cycle decodes as RUN.
  assign freeze      = (state == ERROR) || memBusy_m;
  assign redirect_do = !freeze && pcSrc_e;
  assign stall_do    = !freeze && !pcSrc_e && load_use;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (memBusy_m) begin
          state_nxt    = FREEZE;
          wait_cnt_nxt = WCNT_W'(1);
        end
      end
      FREEZE: begin
        if (!memBusy_m) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WCNT_W'(MAX_WAIT)) begin
          state_nxt = ERROR;
        end else begin
          wait_cnt_nxt = wait_cnt + WCNT_W'(1);
        end
      end
      ERROR: state_nxt = ERROR;
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Reset drives bubbles into every stage and blocks forwarding.
  always_comb begin
    stall_f    = rst_n && (freeze || stall_do);
    stall_d    = rst_n && (freeze || stall_do);
    stall_e    = rst_n && freeze;
    stall_m    = rst_n && freeze;
    flush_d    = !rst_n || redirect_do;
    flush_e    = !rst_n || redirect_do || stall_do;
    flush_w    = !rst_n || freeze;
    forwardA_e = rst_n ? fwd_a : FWD_NONE;
    forwardB_e = rst_n ? fwd_b : FWD_NONE;
    hazard_err = (state == ERROR);
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt  <= '0;
      perf_flush_cnt  <= '0;
      perf_freeze_cnt <= '0;
    end else begin
      if (stall_do && !(&perf_stall_cnt))
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (redirect_do && !(&perf_flush_cnt))
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
      if (freeze && !(&perf_freeze_cnt))
        perf_freeze_cnt <= perf_freeze_cnt + 1'b1;
    end
  end
`else
  // Counter width only matters when the counters are built.
  logic unused_cnt_width;
  assign unused_cnt_width = |CNT_WIDTH;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table plus multi-cycle freeze/error/reset sequences.
module tb_hazard_unit;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       mem_read, pc_src, rw_m, rw_w, busy;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, hazard_err;
  logic [1:0] forwardA_e, forwardB_e;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt;
`endif

  always #5 clk = ~clk;

  hazard_unit #(.MAX_WAIT(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .destinationReg_e(rd_e), .memRead_e(mem_read), .pcSrc_e(pc_src),
    .destinationReg_m(rd_m), .regWrite_m(rw_m),
    .destinationReg_w(rd_w), .regWrite_w(rw_w),
    .memBusy_m(busy),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .forwardA_e(forwardA_e), .forwardB_e(forwardB_e),
    .hazard_err(hazard_err)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_freeze_cnt(perf_freeze_cnt)
`endif
  );

  typedef struct packed {
    logic [3:0] stall;  // f,d,e,m
    logic [2:0] flush;  // d,e,w
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
  } out_t;

  typedef struct {
    string      name;
    logic [4:0] rs1_d, rs2_d, rd_e;
    logic       mem_read, pc_src;
    logic [4:0] rs1_e, rs2_e, rd_m;
    logic       rw_m;
    logic [4:0] rd_w;
    logic       rw_w;
    out_t       want;
  } vec_t;

  typedef struct {
    string name;
    out_t  want;
  } sb_t;

  sb_t  sb[$];
  int   checks = 0;
  int   failures = 0;
  out_t actual;
  out_t o_zero, o_frz, o_lu, o_rd, o_rst, o_err;
  vec_t vt[12];

  assign actual = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
                   forwardA_e, forwardB_e, hazard_err};

  function automatic out_t mk(input logic [3:0] s, input logic [2:0] f,
                              input logic [1:0] a, input logic [1:0] b, input logic e);
    out_t r;
    r.stall = s; r.flush = f; r.fa = a; r.fb = b; r.err = e;
    return r;
  endfunction

  function automatic vec_t mkv(input string n, input logic [4:0] r1d, input logic [4:0] r2d,
                               input logic [4:0] rde, input logic mr, input logic pc,
                               input logic [4:0] r1e, input logic [4:0] r2e,
                               input logic [4:0] rdm, input logic wm,
                               input logic [4:0] rdw, input logic ww, input out_t w);
    vec_t v;
    v.name = n; v.rs1_d = r1d; v.rs2_d = r2d; v.rd_e = rde; v.mem_read = mr; v.pc_src = pc;
    v.rs1_e = r1e; v.rs2_e = r2e; v.rd_m = rdm; v.rw_m = wm; v.rd_w = rdw; v.rw_w = ww;
    v.want = w;
    return v;
  endfunction

  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    mem_read = 0; pc_src = 0; rw_m = 0; rw_w = 0; busy = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    rs1_d = v.rs1_d; rs2_d = v.rs2_d; rd_e = v.rd_e; mem_read = v.mem_read; pc_src = v.pc_src;
    rs1_e = v.rs1_e; rs2_e = v.rs2_e; rd_m = v.rd_m; rw_m = v.rw_m; rd_w = v.rd_w; rw_w = v.rw_w;
  endtask

  // Expected value queued with the stimulus, popped when the outputs are sampled.
  task automatic expect_out(input string name, input out_t want, input bit at_neg);
    sb_t r;
    r.name = name; r.want = want;
    sb.push_back(r);
    if (at_neg) @(negedge clk);
    else #2;
    r = sb.pop_front();
    checks++;
    if (actual !== r.want) begin
      failures++;
      $display("FAIL %s: got %b required %b (stall4 flush3 fa2 fb2 err)", r.name, actual, r.want);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

`ifdef HAZARD_PERF_EN
  task automatic check_cnt(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    o_zero = mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
    o_frz  = mk(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
    o_lu   = mk(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
    o_rd   = mk(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);
    o_rst  = mk(4'b0000, 3'b111, 2'b00, 2'b00, 1'b0);
    o_err  = mk(4'b1111, 3'b001, 2'b00, 2'b00, 1'b1);

    //              name           rs1d rs2d rde mr pc rs1e rs2e rdm wm rdw ww
    vt[0]  = mkv("idle",           0,   0,   0,  0, 0, 0,   0,   0,  0, 0,  0, o_zero);
    vt[1]  = mkv("lu_rs1",         5,   1,   5,  1, 0, 0,   0,   0,  0, 0,  0, o_lu);
    vt[2]  = mkv("lu_rs2",         2,   5,   5,  1, 0, 0,   0,   0,  0, 0,  0, o_lu);
    vt[3]  = mkv("lu_x0",          0,   0,   0,  1, 0, 0,   0,   0,  0, 0,  0, o_zero);
    vt[4]  = mkv("no_load",        5,   0,   5,  0, 0, 0,   0,   0,  0, 0,  0, o_zero);
    vt[5]  = mkv("redir_over_lu",  5,   0,   5,  1, 1, 0,   0,   0,  0, 0,  0, o_rd);
    vt[6]  = mkv("fwd_m_prio",     0,   0,   0,  0, 0, 7,   0,   7,  1, 7,  1, mk(0, 0, 2'b10, 2'b00, 0));
    vt[7]  = mkv("fwd_x0",         0,   0,   0,  0, 0, 0,   0,   0,  1, 0,  1, o_zero);
    vt[8]  = mkv("fwd_w_b",        0,   0,   0,  0, 0, 0,   9,   0,  0, 9,  1, mk(0, 0, 2'b00, 2'b01, 0));
    vt[9]  = mkv("fwd_m_disabled", 0,   0,   0,  0, 0, 7,   0,   7,  0, 7,  1, mk(0, 0, 2'b01, 2'b00, 0));
    vt[10] = mkv("fwd_split",      0,   0,   0,  0, 0, 3,   4,   3,  1, 4,  1, mk(0, 0, 2'b10, 2'b01, 0));
    vt[11] = mkv("fwd_both_m",     0,   0,   0,  0, 0, 6,   6,   6,  1, 0,  0, mk(0, 0, 2'b10, 2'b10, 0));

    clear_inputs();
    rst_n = 1'b0;
    repeat (2) next_cycle();
    expect_out("reset_vals", o_rst, 0);
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 12; i++) begin
      apply_vec(vt[i]);
      expect_out(vt[i].name, vt[i].want, 1);
      next_cycle();
    end

    // Load-use bubble, then the load forwards from M and one cycle later from W.
    clear_inputs();
    rd_e = 5; mem_read = 1; rs1_d = 5;
    expect_out("lu_seq_stall", o_lu, 1);
    next_cycle();
    clear_inputs();
    rs1_e = 5; rd_m = 5; rw_m = 1;
    expect_out("lu_seq_fwd_m", mk(0, 0, 2'b10, 2'b00, 0), 1);
    next_cycle();
    rd_m = 0; rw_m = 0; rd_w = 5; rw_w = 1;
    expect_out("lu_seq_fwd_w", mk(0, 0, 2'b01, 2'b00, 0), 1);
    next_cycle();

    // 16 busy cycles are tolerated; exit cycle with a redirect decodes as RUN.
    clear_inputs();
    busy = 1;
    for (int i = 0; i < 16; i++) begin
      expect_out($sformatf("frz16_%0d", i), o_frz, 1);
      next_cycle();
    end
    busy = 0; pc_src = 1;
    expect_out("frz_exit_redir", o_rd, 1);
    next_cycle();
    pc_src = 0;
    expect_out("after16_run", o_zero, 1);
    next_cycle();

    // 17 busy cycles trap into ERROR, which is sticky until reset.
    busy = 1;
    for (int i = 0; i < 17; i++) begin
      expect_out($sformatf("frz17_%0d", i), o_frz, 1);
      next_cycle();
    end
    busy = 0;
    expect_out("err_trap", o_err, 1);
    next_cycle();
    pc_src = 1; rs1_d = 5; rd_e = 5; mem_read = 1;
    expect_out("err_sticky", o_err, 1);
    next_cycle();
    rs1_e = 7; rd_m = 7; rw_m = 1;
    expect_out("err_fwd", mk(4'b1111, 3'b001, 2'b10, 2'b00, 1), 1);
    rst_n = 1'b0;
    expect_out("err_async_rst", o_rst, 0);
    next_cycle();
    rst_n = 1'b1;
    clear_inputs();
    expect_out("post_err_run", o_zero, 1);
    next_cycle();

    // Asynchronous reset in the middle of a freeze.
    busy = 1;
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("frz_pre_rst_%0d", i), o_frz, 1);
      next_cycle();
    end
    rst_n = 1'b0;
    expect_out("frz_async_rst", o_rst, 0);
    busy = 0;
    rst_n = 1'b1;
    expect_out("frz_rst_release", o_zero, 0);
    next_cycle();
    busy = 1;
    for (int i = 0; i < 16; i++) begin
      expect_out($sformatf("frz_after_rst_%0d", i), o_frz, 1);
      next_cycle();
    end
    busy = 0;
    expect_out("frz_after_rst_exit", o_zero, 1);
    next_cycle();

`ifdef HAZARD_PERF_EN
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    clear_inputs();
    check_cnt("perf_stall_rst", perf_stall_cnt, 0);
    rd_e = 5; mem_read = 1; rs1_d = 5;
    repeat (3) next_cycle();
    clear_inputs();
    pc_src = 1;
    repeat (2) next_cycle();
    clear_inputs();
    busy = 1;
    repeat (5) next_cycle();
    busy = 0;
    next_cycle();
    check_cnt("perf_stall", perf_stall_cnt, 3);
    check_cnt("perf_flush", perf_flush_cnt, 2);
    check_cnt("perf_freeze", perf_freeze_cnt, 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller: the driving end of the `flush`/stall controls consumed by the pipeline registers (F/D, D/E, E/M, M/W), including the `flush` input of the D/E register. It does three things:
- Detects load-use and control-transfer hazards.
- Freezes the pipeline while data memory reports busy, with a watchdog that traps runaway wait states.
- Produces the execute-stage forwarding selects.

## Interface
Parameters:
- MAX_WAIT, 16, maximum consecutive memory-busy cycles tolerated before error trap
- CNT_WIDTH, 32, width of performance counters

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous, active-low reset
- rs1_d, rs2_d  input  5  decode-stage source registers
- rs1_e, rs2_e  input  5  execute-stage source registers
- destinationReg_e  input  5  execute-stage rd
- memRead_e  input  1  execute-stage instruction is a load
- pcSrc_e  input  1  taken branch/jump/jalr resolved in execute
- destinationReg_m, regWrite_m  input  5/1  memory-stage rd and write enable
- destinationReg_w, regWrite_w  input  5/1  writeback-stage rd and write enable
- memBusy_m  input  1  data memory not ready this cycle
- stall_f, stall_d, stall_e, stall_m  output  1  hold PC / F-D / D-E / E-M registers
- flush_d, flush_e, flush_w  output  1  synchronous bubble into F-D / D-E / M-W registers
- forwardA_e, forwardB_e  output  2  ALU operand source select
- hazard_err  output  1  sticky watchdog error

## Operation
- Forwarding, evaluated independently for A (rs1_e) and B (rs2_e), in every state:
  - 2'b10 if regWrite_m && destinationReg_m != 0 && destinationReg_m == rs_e.
  - Else 2'b01 if the same test holds for the W stage.
  - Else 2'b00. M takes priority over W.
- Load-use hazard: memRead_e && destinationReg_e != 0 && (destinationReg_e == rs1_d || destinationReg_e == rs2_d).
- FSM states:
  - **RUN, memBusy_m=1**: freeze outputs this cycle (see below); go to FREEZE with wait_cnt=1. Freeze overrides redirect and load-use.
  - **RUN, pcSrc_e=1**: flush_d=flush_e=1, all stalls 0. Redirect overrides load-use.
  - **RUN, load-use**: stall_f=stall_d=1, flush_e=1.
  - **RUN, otherwise**: all stalls and flushes 0.
  - **FREEZE**: freeze outputs. If memBusy_m=0, go to RUN with wait_cnt=0; that cycle's outputs are the RUN decode. If memBusy_m=1 and wait_cnt==MAX_WAIT, go to ERROR. Otherwise wait_cnt++.
  - **ERROR**: freeze outputs, hazard_err=1. Exits only via reset.
- Freeze outputs: stall_f=stall_d=stall_e=stall_m=1, flush_w=1, flush_d=flush_e=0.
- wait_cnt width is $clog2(MAX_WAIT+1). Up to MAX_WAIT consecutive busy cycles are tolerated; busy on cycle MAX_WAIT+1 enters ERROR at that clock edge.

## Timing
- Stall, flush and forward outputs are combinational from state plus inputs. Zero latency: they are valid in the same cycle, and take effect at the next clk edge in the consuming registers.
- Load-use costs exactly one bubble. Next cycle the load is in M, the hazard clears, and forwarding selects 2'b10 (or 2'b01 one cycle later).
- Redirect costs two bubbles (D and E flushed at the same edge).
- While rst_n=0:
  - state=RUN, wait_cnt=0, hazard_err=0.
  - flush_d=flush_e=flush_w=1; all stalls 0; forwards 2'b00.
- Reset asserted mid-FREEZE or in ERROR returns the FSM to RUN immediately (asynchronous).
- memBusy_m deasserting and pcSrc_e asserting in the same FREEZE cycle: RUN decode applies, so the redirect flush is issued that cycle.

## Configuration
- HAZARD_PERF_EN defined: adds outputs perf_stall_cnt, perf_flush_cnt and perf_freeze_cnt, each CNT_WIDTH bits and saturating at all-ones, all reset to 0. They count:
  - perf_stall_cnt: load-use stall cycles.
  - perf_flush_cnt: redirect cycles.
  - perf_freeze_cnt: FREEZE plus ERROR cycles.
- HAZARD_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package `hazard_pkg`:
  - `fwd_sel_t` enum: FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - `hz_state_t` enum: RUN, FREEZE, ERROR.
  - Default MAX_WAIT constant.
- One sub-module, `fwd_sel`: combinational comparator producing one `fwd_sel_t` from rs, the M rd/write enable and the W rd/write enable. Instantiated twice (A, B).

## Test plan
- Load x5 in E, add using x5 in D → one cycle of stall_f=stall_d=flush_e=1. Next cycle forwardA_e=2'b10 and all stalls are 0.
- pcSrc_e=1 with a simultaneous load-use → flush_d=flush_e=1, stall_f=stall_d=0.
- regWrite_m and regWrite_w both targeting x7, rs1_e=x7 → forwardA_e=2'b10. Target x0 instead → 2'b00.
- memBusy_m high 16 cycles (MAX_WAIT=16) → 16 freeze cycles, then RUN, hazard_err=0. Busy for 17 cycles → ERROR entered, hazard_err=1 held until rst_n is pulsed low.
- rst_n low asynchronously mid-FREEZE → outputs immediately show reset values. Release → RUN, wait_cnt=0.
- With HAZARD_PERF_EN: 3 load-use stalls, 2 redirects, a 5-cycle freeze → counters read 3 / 2 / 5.
